mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares port B of the dual-port video/processor block RAM (15-bit word address, 16-bit data) between two requesters: the processor (P) and an I/O loader/DMA engine (D).
- Port A stays dedicated to the VGA fetch path and is not touched by this block.
- Each cycle the arbiter grants at most one requester using round-robin priority.
- It tracks outstanding reads through a latency pipeline and returns read data with a valid pulse to the requester that issued the read.

Parameters:
- AW, 15, word address width of port B.
- DW, 16, data width of port B.
- RD_LAT, 1, RAM read latency in cycles from address presented to doutb valid; legal range 1..3.
- BURST_LEN, 4, maximum consecutive grants to one requester while the other is waiting; used only with MEM_ARB_BURST_EN.

Ports:
- clk  in  1  system clock; also drives RAM clkb.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  processor access request; level.
- p_we  in  1  processor write enable; qualified by p_req.
- p_addr  in  AW  processor word address.
- p_wdata  in  DW  processor write data.
- p_gnt  out  1  processor access accepted this cycle.
- p_rvalid  out  1  processor read data valid.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid  same as the p_ set, for the DMA/loader.
- rdata  out  DW  shared read data; qualified by p_rvalid or d_rvalid.
- ram_we  out  1  drives RAM web.
- ram_addr  out  AW  drives RAM addrb.
- ram_din  out  DW  drives RAM dinb.
- ram_dout  in  DW  from RAM doutb.

Behaviour:
- Handshake:
  - A requester raises req with we/addr/wdata valid and holds all of them stable until it sees gnt high at a rising edge.
  - gnt is combinational from the req inputs and the arbiter state. The access is presented to the RAM in the same cycle that gnt is high.
  - A requester may keep req high after gnt for a back-to-back access. New values must be presented on the cycle after gnt.
- Arbitration:
  - Register last_win (0=P, 1=D) records the most recent winner.
  - Only one requester active: that requester wins.
  - Both active: the requester that is not last_win wins.
  - Neither active: no grant, ram_we=0, and last_win holds.
- RAM drive:
  - ram_addr/ram_din/ram_we are muxed from the winner.
  - ram_we = winner's we AND gnt.
  - With no grant, ram_addr/ram_din hold their previous values and ram_we=0.
- Read pipeline:
  - A granted read (we=0) pushes tag {valid=1, owner} into an RD_LAT-deep shift register. Writes and idle cycles push valid=0.
  - At the pipeline output, a valid tag pulses the owner's rvalid for exactly 1 cycle. rdata = ram_dout unconditionally.
  - Read latency, gnt to rvalid, is exactly RD_LAT cycles. This includes back-to-back reads from alternating owners.
- Writes: no completion signal. Write data is in RAM from the edge at which gnt is high.
- Same-address write then read: read data follows the RAM's port-B mode (write-first). The arbiter adds no forwarding.
- Reset:
  - last_win=D, so P wins the first tie.
  - Pipeline valids cleared; p_rvalid=d_rvalid=0; ram_we=0; ram_addr=0; ram_din=0.
  - gnt is forced to 0 while reset is high.
  - A read granted in the cycle before reset asserts is dropped: no rvalid after reset.
- No requester waits more than 1 cycle (2-requester round-robin). Burst mode raises this bound to BURST_LEN.

Optional Feature:
- Macro: MEM_ARB_BURST_EN.
- Defined:
  - The winner keeps priority while its req stays high, up to BURST_LEN consecutive grants.
  - A burst counter resets to 0 on a switch of owner or on a gap in req.
  - When the counter reaches BURST_LEN-1 and the other requester is requesting, priority flips.
  - Maximum wait for the other requester is BURST_LEN cycles.
- Undefined: strict alternation on every contended cycle, as described above. The counter logic is absent.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_AW=15, MEM_DW=16.
  - Owner encoding OWN_P=0, OWN_D=1.
  - Tag struct {valid, owner}.
  - VGA/processor RAM depth constant.
- One sub-module, rd_tag_pipe: a parameterized RD_LAT-deep shift register of tags with synchronous reset.

Test Plan:
- Reset, then P read addr 0x0010 only, RAM preloaded 0x0010=0xBEEF → p_gnt same cycle; p_rvalid=1, rdata=0xBEEF exactly RD_LAT cycles later; d_rvalid stays 0.
- P and D both request continuously from reset: P reads 0x0001..0x0004, D writes 0x1000..0x1003 → grants alternate P,D,P,D starting with P; 4 writes land; 4 p_rvalid pulses in order.
- D write 0x2000=0x1234, then D read 0x2000 next cycle → d_rvalid with rdata=0x1234.
- Contention with MEM_ARB_BURST_EN and BURST_LEN=4: D holds req, P requests from cycle 1 → D granted 4 consecutive cycles, then P; P waits ≤4 cycles.
- P read granted, reset asserted next cycle for 2 cycles → no p_rvalid after reset; first tie after reset goes to P.
- Idle cycles: no req for 5 cycles → ram_we=0 throughout; ram_addr holds its last value; no rvalid pulses.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths, owner encoding and read-tag type for the
//               video/processor block RAM port-B arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int MEM_AW    = 15;
    localparam int MEM_DW    = 16;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    function automatic rd_tag_t make_tag(input logic valid, input logic owner);
        rd_tag_t t;
        t.valid = valid;
        t.owner = owner;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_tag_pipe
// Description : DEPTH-stage shift register of read tags, synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_tag,
    output logic [1:0] o_tag
);

    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= rd_tag_t'(i_tag);
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing RAM port B between processor (P)
//               and DMA/loader (D), with read-data return tagging.
//               Optional burst priority enabled by defining MEM_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int RD_LAT    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic          r_last_win;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_din_hold;

    logic          w_keep;
    logic          w_win;
    logic          w_gnt;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    rd_tag_t       w_tag_in;
    rd_tag_t       w_tag_out;

`ifdef MEM_ARB_BURST_EN
    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(BURST_LEN - 1);

    logic          r_granted;
    logic [CW-1:0] r_burst_cnt;

    // The last winner keeps priority only while its run is unbroken and short.
    assign w_keep = r_granted && (r_burst_cnt != C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_granted   <= 1'b0;
            r_burst_cnt <= '0;
        end else if (w_gnt) begin
            r_granted <= 1'b1;
            if (r_granted && (w_win == r_last_win)) begin
                if (r_burst_cnt != C_CNT_MAX) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else begin
                r_burst_cnt <= '0;
            end
        end else begin
            r_granted   <= 1'b0;
            r_burst_cnt <= '0;
        end
    end
`else
    // Strict alternation: only a degenerate BURST_LEN could make this true.
    assign w_keep = (BURST_LEN < 1);
`endif

    always_comb begin
        w_win = d_req;
        if (p_req && d_req) begin
            w_win = w_keep ? r_last_win : ~r_last_win;
        end
    end

    assign w_gnt   = ~reset & (p_req | d_req);
    assign p_gnt   = w_gnt & (w_win == OWN_P);
    assign d_gnt   = w_gnt & (w_win == OWN_D);
    assign w_we    = (w_win == OWN_D) ? d_we    : p_we;
    assign w_addr  = (w_win == OWN_D) ? d_addr  : p_addr;
    assign w_wdata = (w_win == OWN_D) ? d_wdata : p_wdata;

    assign ram_we   = w_gnt & w_we;
    assign ram_addr = w_gnt ? w_addr  : r_addr_hold;
    assign ram_din  = w_gnt ? w_wdata : r_din_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_win  <= OWN_D;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
        end else if (w_gnt) begin
            r_last_win  <= w_win;
            r_addr_hold <= w_addr;
            r_din_hold  <= w_wdata;
        end
    end

    assign w_tag_in = make_tag(w_gnt & ~w_we, w_win);

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Gating by reset drops a read that was in flight when reset arrived.
    assign p_rvalid = ~reset & w_tag_out.valid & (w_tag_out.owner == OWN_P);
    assign d_rvalid = ~reset & w_tag_out.valid & (w_tag_out.owner == OWN_D);
    assign rdata    = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized self-checking bench for mem_port_arbiter with a
//               transaction-level reference model and a write-first RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int RD_LAT    = 1;
    localparam int BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_gnt, p_rvalid, d_gnt, d_rvalid;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [14:0] ram_addr;
    logic        ram_we;

    bit          t_req   [2];
    bit          t_we    [2];
    logic [14:0] t_addr  [2];
    logic [15:0] t_wdata [2];
    bit          busy    [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW        (15),
        .DW        (16),
        .RD_LAT    (RD_LAT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_req    (t_req[0]),
        .p_we     (t_we[0]),
        .p_addr   (t_addr[0]),
        .p_wdata  (t_wdata[0]),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .d_req    (t_req[1]),
        .d_we     (t_we[1]),
        .d_addr   (t_addr[1]),
        .d_wdata  (t_wdata[1]),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Write-first block RAM port B
    logic [15:0] ram_mem   [MEM_DEPTH];
    logic [15:0] dout_pipe [RD_LAT];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        dout_pipe[0] <= ram_we ? ram_din : ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) dout_pipe[i] <= dout_pipe[i-1];
    end
    assign ram_dout = dout_pipe[RD_LAT-1];

    typedef struct {
        bit          idle;
        bit          we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        int          cyc;
        bit          owner;
        logic [15:0] data;
    } rd_evt_t;

    txn_t        tq [2][$];
    rd_evt_t     evq[$];
    logic [15:0] ref_mem [MEM_DEPTH];
    bit          m_last;
    int          m_run;
    logic [14:0] m_addr_hold;
    logic [15:0] m_din_hold;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Arbitration rules stated in terms of run length of the last winner.
    function automatic bit pick_winner(input bit pr, input bit dr);
        if (pr && dr) begin
`ifdef MEM_ARB_BURST_EN
            if (m_run > 0 && m_run < BURST_LEN) return m_last;
`endif
            return !m_last;
        end
        return dr;
    endfunction

    task automatic advance(input int i, input bit granted);
        txn_t t;
        if (busy[i] && !granted) return;
        busy[i]  = 1'b0;
        t_req[i] = 1'b0;
        if (tq[i].size() > 0) begin
            t = tq[i].pop_front();
            if (!t.idle) begin
                busy[i]    = 1'b1;
                t_req[i]   = 1'b1;
                t_we[i]    = t.we;
                t_addr[i]  = t.addr;
                t_wdata[i] = t.wdata;
            end
        end
    endtask

    task automatic step();
        bit          granted, win, e_pg, e_dg, e_we, e_prv, e_drv;
        logic [14:0] e_addr;
        logic [15:0] e_din, e_rdata;
        @(negedge clk);
        e_pg = 0; e_dg = 0; e_we = 0; e_prv = 0; e_drv = 0; win = 0;
        e_addr = m_addr_hold; e_din = m_din_hold; e_rdata = '0;
        granted = !reset && (t_req[0] || t_req[1]);
        if (granted) begin
            win    = pick_winner(t_req[0], t_req[1]);
            e_pg   = !win;
            e_dg   = win;
            e_we   = t_we[win];
            e_addr = t_addr[win];
            e_din  = t_wdata[win];
        end
        if (!reset && evq.size() > 0 && evq[0].cyc == cyc) begin
            e_prv   = (evq[0].owner == 1'b0);
            e_drv   = (evq[0].owner == 1'b1);
            e_rdata = evq[0].data;
            void'(evq.pop_front());
        end
        chk_eq("p_gnt", 32'(p_gnt), 32'(e_pg));
        chk_eq("d_gnt", 32'(d_gnt), 32'(e_dg));
        chk_eq("ram_we", 32'(ram_we), 32'(e_we));
        if (!reset) begin
            chk_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk_eq("ram_din", 32'(ram_din), 32'(e_din));
        end
        chk_eq("p_rvalid", 32'(p_rvalid), 32'(e_prv));
        chk_eq("d_rvalid", 32'(d_rvalid), 32'(e_drv));
        if (e_prv || e_drv) chk_eq("rdata", 32'(rdata), 32'(e_rdata));

        if (reset) begin
            evq.delete();
            m_last = 1'b1;
            m_run = 0;
            m_addr_hold = '0;
            m_din_hold = '0;
        end else if (granted) begin
            if (e_we) ref_mem[e_addr] = e_din;
            else evq.push_back('{cyc + RD_LAT, win, ref_mem[e_addr]});
            m_run = (win == m_last && m_run > 0) ? m_run + 1 : 1;
            m_last = win;
            m_addr_hold = e_addr;
            m_din_hold = e_din;
        end else begin
            m_run = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        advance(0, e_pg);
        advance(1, e_dg);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy[0] || busy[1] || tq[0].size() > 0 || tq[1].size() > 0 ||
                evq.size() > 0) && n < 5000) begin
            step();
            n++;
        end
        chk_eq("drain_bound", 32'(n < 5000), 32'd1);
        repeat (RD_LAT + 1) step();
    endtask

    function automatic txn_t mk(input bit we, input logic [14:0] a, input logic [15:0] d);
        txn_t t;
        t.idle = 0; t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t idle_t();
        txn_t t;
        t.idle = 1; t.we = 0; t.addr = '0; t.wdata = '0;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            ram_mem[i] = 16'(i * 7);
            ref_mem[i] = 16'(i * 7);
        end
        ram_mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            t_req[i] = 0; t_we[i] = 0; t_addr[i] = '0; t_wdata[i] = '0; busy[i] = 0;
        end
        m_last = 1; m_run = 0; m_addr_hold = '0; m_din_hold = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // single processor read of a preloaded word
        tq[0].push_back(mk(0, 15'h0010, '0));
        drain();

        // both requesting continuously: P reads, D writes, then read writes back
        for (int i = 0; i < 4; i++) begin
            tq[0].push_back(mk(0, 15'(1 + i), '0));
            tq[1].push_back(mk(1, 15'(16'h1000 + i), 16'(16'hA500 + i)));
        end
        drain();
        for (int i = 0; i < 4; i++) tq[0].push_back(mk(0, 15'(16'h1000 + i), '0));
        drain();

        // write then read the same address back-to-back
        tq[1].push_back(mk(1, 15'h2000, 16'h1234));
        tq[1].push_back(mk(0, 15'h2000, '0));
        drain();

        // D holds request, P joins one cycle later
        for (int i = 0; i < 6; i++) tq[1].push_back(mk(0, 15'(16'h0100 + i), '0));
        tq[0].push_back(idle_t());
        for (int i = 0; i < 3; i++) tq[0].push_back(mk(0, 15'(16'h0200 + i), '0));
        drain();

        // read in flight when reset arrives, then first tie after reset
        tq[0].push_back(mk(0, 15'h0010, '0));
        step();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tq[0].push_back(mk(0, 15'h0003, '0));
        tq[1].push_back(mk(0, 15'h0004, '0));
        drain();

        // idle stretch
        for (int i = 0; i < 5; i++) begin
            tq[0].push_back(idle_t());
            tq[1].push_back(idle_t());
        end
        drain();

        // randomized traffic over a small address window
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) tq[k].push_back(idle_t());
                else tq[k].push_back(mk(1'($urandom_range(0, 1)),
                                        15'($urandom_range(0, 31)),
                                        16'($urandom)));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
